// File: rtl/gppcu_cmd_master_if.sv
// gppcu_cmd_master_if
// Request/completion handshake and test-queue command bus for gppcu_cmd_master.
//   master modport : the command initiator (drives ready, completion, oCMD, oDATA)
//   slave  modport : the requester / queue model on the other side
// Signals:
//   iREQ_VALID/oREQ_READY        request handshake
//   iREQ_OP/THREAD/ADDR/WDATA    request fields
//   oRSP_VALID/oRSP_DATA         completion pulse and read data
//   oCMD/oDATA                   command word (bit 31 = software clock) and data word
//   iDATA                        read-back word from the queue
//   iFULL/iDONE                  queue status, asynchronous to the system clock
interface gppcu_cmd_master_if;
    logic        iREQ_VALID;
    logic        oREQ_READY;
    logic [2:0]  iREQ_OP;
    logic [7:0]  iREQ_THREAD;
    logic [15:0] iREQ_ADDR;
    logic [31:0] iREQ_WDATA;
    logic        oRSP_VALID;
    logic [31:0] oRSP_DATA;
    logic [31:0] oCMD;
    logic [31:0] oDATA;
    logic [31:0] iDATA;
    logic        iFULL;
    logic        iDONE;

    modport master (
        input  iREQ_VALID, iREQ_OP, iREQ_THREAD, iREQ_ADDR, iREQ_WDATA,
        input  iDATA, iFULL, iDONE,
        output oREQ_READY, oRSP_VALID, oRSP_DATA, oCMD, oDATA
    );

    modport slave (
        output iREQ_VALID, iREQ_OP, iREQ_THREAD, iREQ_ADDR, iREQ_WDATA,
        output iDATA, iFULL, iDONE,
        input  oREQ_READY, oRSP_VALID, oRSP_DATA, oCMD, oDATA
    );
endinterface

// File: rtl/gppcu_cmd_master.sv
// gppcu_cmd_master
// Host-side command initiator for the GPPCU test queue. Accepts one request at a
// time, generates a software clock pulse on oCMD[31] with programmable setup,
// high and hold phases, captures read-back data and issues one completion per
// accepted request.
// Ports:
//   iACLK : system clock, all logic on its rising edge
//   iRST  : asynchronous active-high reset
//   bus   : gppcu_cmd_master_if.master (request, completion and queue bus)
// Parameters: SETUP_CYC, HIGH_CYC, HOLD_CYC (each 1..15 cycles).
// Build option: define GPPCU_CMD_DONE_WAIT_EN to enable op 5 (WAITDONE) and the
// iDONE synchronizer; otherwise op 5 is treated as illegal and iDONE is ignored.
module gppcu_cmd_master #(
    parameter logic [3:0] SETUP_CYC = 4'd1,
    parameter logic [3:0] HIGH_CYC  = 4'd2,
    parameter logic [3:0] HOLD_CYC  = 4'd1
) (
    input  logic                      iACLK,
    input  logic                      iRST,
    gppcu_cmd_master_if.master        bus
);

    localparam logic [2:0]  OP_PUSH     = 3'd0;
    localparam logic [2:0]  OP_RDL      = 3'd1;
    localparam logic [2:0]  OP_WRL      = 3'd2;
    localparam logic [2:0]  OP_WRG      = 3'd3;
    localparam logic [2:0]  OP_STAT     = 3'd4;
`ifdef GPPCU_CMD_DONE_WAIT_EN
    localparam logic [2:0]  OP_WAITDONE = 3'd5;
`endif
    localparam logic [31:0] IDLE_CMD    = 32'h7F00_0000;

`ifdef GPPCU_CMD_DONE_WAIT_EN
    typedef enum logic [2:0] {
        IDLE, FULLWAIT, SETUP, HIGH, HOLD, RESP, DONEWAIT
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, FULLWAIT, SETUP, HIGH, HOLD, RESP
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  thread_q, thread_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [31:0] cmd_q, cmd_d;
    logic [31:0] data_q, data_d;
    logic        full_meta_q, full_s_q;
`ifdef GPPCU_CMD_DONE_WAIT_EN
    logic        done_meta_q, done_s_q;
`else
    logic        unused_done_s;
    assign unused_done_s = bus.iDONE;
`endif

    // Assemble the command word from latched request fields; lparam and
    // command are only meaningful for the ops that address a thread/register.
    function automatic logic [31:0] build_cmd(input logic        clk_bit,
                                              input logic [2:0]  op,
                                              input logic [7:0]  thread,
                                              input logic [15:0] addr);
        logic [7:0]  lparam;
        logic [15:0] command;
        lparam  = ((op == OP_RDL) || (op == OP_WRL)) ? thread : 8'd0;
        command = ((op == OP_RDL) || (op == OP_WRL) || (op == OP_WRG)) ? addr : 16'd0;
        return {clk_bit, 4'b0000, op, lparam, command};
    endfunction

    // Two-flop synchronizers for the asynchronous queue status flags.
    always_ff @(posedge iACLK or posedge iRST) begin
        if (iRST) begin
            full_meta_q <= 1'b0;
            full_s_q    <= 1'b0;
`ifdef GPPCU_CMD_DONE_WAIT_EN
            done_meta_q <= 1'b0;
            done_s_q    <= 1'b0;
`endif
        end else begin
            full_meta_q <= bus.iFULL;
            full_s_q    <= full_meta_q;
`ifdef GPPCU_CMD_DONE_WAIT_EN
            done_meta_q <= bus.iDONE;
            done_s_q    <= done_meta_q;
`endif
        end
    end

    // Next-state, phase counter, request latch and completion data.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        thread_d   = thread_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (bus.iREQ_VALID) begin
                    op_d     = bus.iREQ_OP;
                    thread_d = bus.iREQ_THREAD;
                    addr_d   = bus.iREQ_ADDR;
                    wdata_d  = bus.iREQ_WDATA;
                    case (bus.iREQ_OP)
                        OP_PUSH: begin
                            if (full_s_q) begin
                                state_d = FULLWAIT;
                            end else begin
                                state_d = SETUP;
                                cnt_d   = SETUP_CYC - 4'd1;
                            end
                        end
                        OP_RDL, OP_WRL, OP_WRG, OP_STAT: begin
                            state_d = SETUP;
                            cnt_d   = SETUP_CYC - 4'd1;
                        end
`ifdef GPPCU_CMD_DONE_WAIT_EN
                        OP_WAITDONE: begin
                            state_d = DONEWAIT;
                        end
`endif
                        default: begin
                            // Illegal op: complete at once without a bus cycle.
                            state_d    = RESP;
                            rsp_data_d = 32'hFFFF_FFFF;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            FULLWAIT: begin
                if (!full_s_q) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_CYC - 4'd1;
                end else begin
                    state_d = FULLWAIT;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = HIGH;
                    cnt_d   = HIGH_CYC - 4'd1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HIGH: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_CYC - 4'd1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    // Queue drives read-back data while the fields are held.
                    if ((op_q == OP_RDL) || (op_q == OP_STAT)) begin
                        rsp_data_d = bus.iDATA;
                    end else begin
                        rsp_data_d = 32'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
`ifdef GPPCU_CMD_DONE_WAIT_EN
            DONEWAIT: begin
                if (done_s_q) begin
                    state_d    = RESP;
                    rsp_data_d = 32'd0;
                end else begin
                    state_d = DONEWAIT;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output words are derived from the next state so they are registered
    // yet line up exactly with the state they belong to.
    always_comb begin
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        cmd_d       = IDLE_CMD;
        data_d      = 32'd0;
        case (state_d)
            SETUP, HOLD: begin
                cmd_d = build_cmd(1'b0, op_d, thread_d, addr_d);
            end
            HIGH: begin
                cmd_d = build_cmd(1'b1, op_d, thread_d, addr_d);
            end
            default: begin
                cmd_d = IDLE_CMD;
            end
        endcase
        if (((state_d == SETUP) || (state_d == HIGH) || (state_d == HOLD)) &&
            ((op_d == OP_PUSH) || (op_d == OP_WRL) || (op_d == OP_WRG))) begin
            data_d = wdata_d;
        end else begin
            data_d = 32'd0;
        end
    end

    // State, latched request and registered outputs; reset drops to the idle word.
    always_ff @(posedge iACLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            op_q        <= 3'd0;
            thread_q    <= 8'd0;
            addr_q      <= 16'd0;
            wdata_q     <= 32'd0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            cmd_q       <= IDLE_CMD;
            data_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            thread_q    <= thread_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
        end
    end

    assign bus.oREQ_READY = ready_q;
    assign bus.oRSP_VALID = rsp_valid_q;
    assign bus.oRSP_DATA  = rsp_data_q;
    assign bus.oCMD       = cmd_q;
    assign bus.oDATA      = data_q;

endmodule

// File: tb/tb_gppcu_cmd_master.sv
// Testbench for gppcu_cmd_master (default parameters 1/2/1).
module tb_gppcu_cmd_master;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [31:0] sb[$];

    gppcu_cmd_master_if bus();

    gppcu_cmd_master dut (
        .iACLK (clk),
        .iRST  (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completion monitor: every pulse pops one expected response.
    always @(negedge clk) begin
        if (!rst && (bus.oRSP_VALID === 1'b1)) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL rsp_unexpected: got completion data %h, required no completion", bus.oRSP_DATA);
            end else begin
                logic [31:0] exp_v;
                exp_v = sb.pop_front();
                if (bus.oRSP_DATA !== exp_v) begin
                    tests_failed++;
                    $display("FAIL rsp_data: got %h, required %h", bus.oRSP_DATA, exp_v);
                end
            end
        end
    end

    // Wait for ready, present a request for one cycle; returns at cycle 1.
    task automatic issue(input logic [2:0] op, input logic [7:0] thr,
                         input logic [15:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rsp, input logic track);
        int n;
        n = 0;
        while ((bus.oREQ_READY !== 1'b1) && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests_run++;
            tests_failed++;
            $display("FAIL ready_timeout: got ready %b, required 1", bus.oREQ_READY);
        end
        bus.iREQ_VALID  = 1'b1;
        bus.iREQ_OP     = op;
        bus.iREQ_THREAD = thr;
        bus.iREQ_ADDR   = addr;
        bus.iREQ_WDATA  = wd;
        if (track) sb.push_back(exp_rsp);
        @(negedge clk);
        bus.iREQ_VALID  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ((bus.oCMD !== 32'h7F00_0000) || (bus.oDATA !== 32'd0) || (bus.oREQ_READY !== 1'b1) ||
            (bus.oRSP_VALID !== 1'b0) || (bus.oRSP_DATA !== 32'd0)) begin
            tests_failed++;
            $display("FAIL reset_values: got cmd %h data %h rdy %b vld %b rsp %h, required 7f000000 0 1 0 0",
                     bus.oCMD, bus.oDATA, bus.oREQ_READY, bus.oRSP_VALID, bus.oRSP_DATA);
        end
        // Abort a PUSH while the clock bit is high; no completion expected.
        issue(3'd0, 8'h00, 16'h0000, 32'h1111_2222, 32'd0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (bus.oCMD[31] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_pre_high: got cmd %h, required bit31 set", bus.oCMD);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ((bus.oCMD !== 32'h7F00_0000) || (bus.oDATA !== 32'd0)) begin
            tests_failed++;
            $display("FAIL reset_async: got cmd %h data %h, required 7f000000 0", bus.oCMD, bus.oDATA);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (bus.oREQ_READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b, required 1", bus.oREQ_READY);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_push();
        logic [31:0] exp_cmd, exp_data;
        logic        exp_vld;
        issue(3'd0, 8'hAA, 16'h5555, 32'hDEAD_BEEF, 32'd0, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            exp_cmd  = (c <= 4) ? (((c == 2) || (c == 3)) ? 32'h8000_0000 : 32'h0000_0000) : 32'h7F00_0000;
            exp_data = (c <= 4) ? 32'hDEAD_BEEF : 32'd0;
            exp_vld  = (c == 5);
            tests_run++;
            if ((bus.oCMD !== exp_cmd) || (bus.oDATA !== exp_data) || (bus.oRSP_VALID !== exp_vld) ||
                (bus.oREQ_READY !== (c == 6))) begin
                tests_failed++;
                $display("FAIL push_cycle%0d: got cmd %h data %h vld %b rdy %b, required %h %h %b %b",
                         c, bus.oCMD, bus.oDATA, bus.oRSP_VALID, bus.oREQ_READY, exp_cmd, exp_data, exp_vld, c == 6);
            end
            if (c < 6) @(negedge clk);
        end
    endtask

    task automatic test_rdl();
        logic [31:0] exp_cmd;
        bus.iDATA = 32'h1234_5678;
        issue(3'd1, 8'h03, 16'h0012, 32'hCAFE_0000, 32'h1234_5678, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            exp_cmd = (c <= 4) ? (((c == 2) || (c == 3)) ? 32'h8103_0012 : 32'h0103_0012) : 32'h7F00_0000;
            tests_run++;
            if ((bus.oCMD !== exp_cmd) || (bus.oDATA !== 32'd0)) begin
                tests_failed++;
                $display("FAIL rdl_cycle%0d: got cmd %h data %h, required %h 0", c, bus.oCMD, bus.oDATA, exp_cmd);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fullwait();
        logic seen;
        int   n;
        bus.iFULL = 1'b1;
        repeat (3) @(negedge clk);
        issue(3'd0, 8'h00, 16'h0000, 32'h0BAD_CAFE, 32'd0, 1'b1);
        seen = 1'b0;
        for (int c = 1; c < 20; c++) begin
            if ((bus.oCMD[31] !== 1'b0) || (bus.oRSP_VALID !== 1'b0)) seen = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_stall: got activity %b while full, required 0", seen);
        end
        bus.iFULL = 1'b0;
        n = 0;
        while ((bus.oCMD[31] !== 1'b1) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        // Two synchronizer edges, one FULLWAIT->SETUP edge, one SETUP->HIGH edge.
        tests_run++;
        if (n != 4) begin
            tests_failed++;
            $display("FAIL full_release: got clock rise after %0d edges, required 4", n);
        end
        tests_run++;
        if (bus.oDATA !== 32'h0BAD_CAFE) begin
            tests_failed++;
            $display("FAIL full_data: got %h, required 0badcafe", bus.oDATA);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_stat();
        bus.iDATA = 32'h0005_0002;
        issue(3'd4, 8'h77, 16'h9999, 32'h1357_9BDF, 32'h0005_0002, 1'b1);
        @(negedge clk);
        tests_run++;
        if ((bus.oCMD !== 32'h8400_0000) || (bus.oDATA !== 32'd0)) begin
            tests_failed++;
            $display("FAIL stat_cmd: got cmd %h data %h, required 84000000 0", bus.oCMD, bus.oDATA);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        issue(3'd3, 8'h12, 16'h4321, 32'hA5A5_0001, 32'd0, 1'b1);
        tests_run++;
        if ((bus.oCMD !== 32'h0300_4321) || (bus.oDATA !== 32'hA5A5_0001)) begin
            tests_failed++;
            $display("FAIL wrg_cmd: got cmd %h data %h, required 03004321 a5a50001", bus.oCMD, bus.oDATA);
        end
        issue(3'd2, 8'h55, 16'hABCD, 32'h0BAD_F00D, 32'd0, 1'b1);
        tests_run++;
        if ((bus.oCMD !== 32'h0255_ABCD) || (bus.oDATA !== 32'h0BAD_F00D)) begin
            tests_failed++;
            $display("FAIL wrl_cmd: got cmd %h data %h, required 0255abcd 0badf00d", bus.oCMD, bus.oDATA);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_op5_op7();
        int   n;
        logic seen;
`ifdef GPPCU_CMD_DONE_WAIT_EN
        bus.iDONE = 1'b0;
        issue(3'd5, 8'h00, 16'h0000, 32'd0, 32'd0, 1'b1);
        seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if ((bus.oRSP_VALID !== 1'b0) || (bus.oCMD !== 32'h7F00_0000)) seen = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL waitdone_early: got activity %b before done, required 0", seen);
        end
        bus.iDONE = 1'b1;
        n = 0;
        while ((bus.oRSP_VALID !== 1'b1) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n != 3) begin
            tests_failed++;
            $display("FAIL waitdone_latency: got %0d edges, required 3", n);
        end
        @(negedge clk);
        bus.iDONE = 1'b0;
`else
        bus.iDONE = 1'b1;
        issue(3'd5, 8'h00, 16'h0000, 32'd0, 32'hFFFF_FFFF, 1'b1);
        tests_run++;
        if ((bus.oRSP_VALID !== 1'b1) || (bus.oCMD !== 32'h7F00_0000)) begin
            tests_failed++;
            $display("FAIL op5_illegal: got vld %b cmd %h, required 1 7f000000", bus.oRSP_VALID, bus.oCMD);
        end
        bus.iDONE = 1'b0;
`endif
        repeat (2) @(negedge clk);
        issue(3'd7, 8'h01, 16'h0001, 32'h1, 32'hFFFF_FFFF, 1'b1);
        seen = 1'b0;
        tests_run++;
        if ((bus.oRSP_VALID !== 1'b1) || (bus.oCMD !== 32'h7F00_0000)) begin
            tests_failed++;
            $display("FAIL op7_illegal: got vld %b cmd %h, required 1 7f000000", bus.oRSP_VALID, bus.oCMD);
        end
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            if (bus.oCMD[31] !== 1'b0) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL op7_pulse: got clock pulse %b, required 0", seen);
        end
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst             = 1'b1;
        bus.iREQ_VALID  = 1'b0;
        bus.iREQ_OP     = 3'd0;
        bus.iREQ_THREAD = 8'd0;
        bus.iREQ_ADDR   = 16'd0;
        bus.iREQ_WDATA  = 32'd0;
        bus.iDATA       = 32'd0;
        bus.iFULL       = 1'b0;
        bus.iDONE       = 1'b0;
        @(negedge clk);
        test_reset();
        test_push();
        test_rdl();
        test_fullwait();
        test_stat();
        test_back_to_back();
        test_op5_op7();
        repeat (10) @(negedge clk);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL rsp_missing: got %0d outstanding completions, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
